// File: rtl/demux_stream_router_pkg.sv
// Shared constants and types for the 4-way stream router and its channel FIFOs.
package demux_router_pkg;
  localparam int NUM_CH     = 4;
  localparam int DEST_W     = 2;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;
  localparam int CNT_W_DEF  = 16;

  typedef logic [DEST_W-1:0] dest_t;
endpackage

// File: rtl/demux_stream_router_if.sv
// Input stream and per-channel output bundle of demux_stream_router.
// out_cnt (and the CNT_W parameter) exist only when DEMUX_ROUTER_CNT_EN is defined.
interface demux_stream_router_if
  import demux_router_pkg::*;
  #(
    parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_ROUTER_CNT_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
  );
  logic                     in_valid;
  logic                     in_ready;
  dest_t                    in_dest;
  logic [DATA_W-1:0]        in_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
`ifdef DEMUX_ROUTER_CNT_EN
  logic [NUM_CH*CNT_W-1:0]  out_cnt;
`endif

  modport master (
    output in_valid, in_dest, in_data, out_ready,
    input  in_ready, out_valid, out_data
`ifdef DEMUX_ROUTER_CNT_EN
    , input out_cnt
`endif
  );

  modport slave (
    input  in_valid, in_dest, in_data, out_ready,
    output in_ready, out_valid, out_data
`ifdef DEMUX_ROUTER_CNT_EN
    , output out_cnt
`endif
  );
endinterface

// File: rtl/demux_chan_fifo.sv
// Single-clock FIFO with a separate occupancy count driving full/empty.
module demux_chan_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-4 stream router with a small FIFO per output channel.
// Define DEMUX_ROUTER_CNT_EN to add per-channel accepted-beat counters on out_cnt.
module demux_stream_router
  import demux_router_pkg::*;
  #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
  ) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_stream_router_if.slave  bus
  );

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("demux_stream_router: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
  end

  logic              run;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] rdata [NUM_CH];

  // Holds in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign bus.in_ready  = run & ~full[bus.in_dest];
  assign bus.out_valid = ~empty;
  assign pop           = bus.out_ready & bus.out_valid;

  always_comb begin
    push = '0;
    if (bus.in_valid && bus.in_ready) push[bus.in_dest] = 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .pop   (pop[k]),
      .wdata (bus.in_data),
      .rdata (rdata[k]),
      .full  (full[k]),
      .empty (empty[k])
    );

    assign bus.out_data[k*DATA_W +: DATA_W] = rdata[k];

`ifdef DEMUX_ROUTER_CNT_EN
    logic [CNT_W-1:0] beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       beat_cnt <= '0;
      else if (push[k]) beat_cnt <= beat_cnt + 1'b1;
    end

    assign bus.out_cnt[k*CNT_W +: CNT_W] = beat_cnt;
`endif
  end
endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router: directed and random beats checked against a queue-per-channel model.
// Build with DEMUX_ROUTER_CNT_EN defined to also check out_cnt (CNT_W=4, so counters wrap at 16).
module tb_demux_stream_router;
  import demux_router_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_stream_router_if #(
    .DATA_W (DW)
`ifdef DEMUX_ROUTER_CNT_EN
    , .CNT_W (CW)
`endif
  ) bus ();

  demux_stream_router #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: one queue per channel, beat counts, and the post-reset ready gate.
  logic [DW-1:0] q [NUM_CH][$];
  int            cnt [NUM_CH];
  bit            live;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < NUM_CH; k++) begin
      q[k].delete();
      cnt[k] = 0;
    end
    live = 1'b0;
  endtask

  // Drive one cycle of stimulus, check outputs against the model, then advance past the edge.
  task automatic step(input bit v, input logic [1:0] d, input logic [DW-1:0] dat,
                      input logic [3:0] rdy, output bit acc);
    bit            exp_rdy;
    logic [3:0]    exp_v;
    logic [3:0]    pops;
    logic [DW-1:0] tmp;
    bus.in_valid  = v;
    bus.in_dest   = d;
    bus.in_data   = dat;
    bus.out_ready = rdy;
    #1;
    exp_rdy = live && (q[d].size() < DEPTH);
    for (int k = 0; k < NUM_CH; k++) exp_v[k] = (q[k].size() != 0);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    for (int k = 0; k < NUM_CH; k++)
      if (exp_v[k]) chk($sformatf("out_data%0d", k), 32'(bus.out_data[k*DW +: DW]), 32'(q[k][0]));
`ifdef DEMUX_ROUTER_CNT_EN
    for (int k = 0; k < NUM_CH; k++)
      chk($sformatf("out_cnt%0d", k), 32'(bus.out_cnt[k*CW +: CW]), 32'(cnt[k] % (1 << CW)));
`endif
    pops = exp_v & rdy;
    acc  = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < NUM_CH; k++)
      if (pops[k]) tmp = q[k].pop_front();
    if (acc) begin
      q[d].push_back(dat);
      cnt[d]++;
    end
    if (rst_n) live = 1'b1;
    #1;
  endtask

  task automatic idle(input logic [3:0] rdy, input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, rdy, acc);
  endtask

  task automatic send(input logic [1:0] d, input logic [DW-1:0] dat, input logic [3:0] rdy);
    bit acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(1'b1, d, dat, rdy, acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    logic [1:0]    d;
    logic [DW-1:0] dat;

    bus.in_valid  = 1'b0;
    bus.in_dest   = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    reset_model();

    // Power-on reset
    #12;
    chk("por_out_valid", 32'(bus.out_valid), 32'd0);
    chk("por_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    idle(4'hF, 2);

    // Single route to channel 3, popped on first visibility
    step(1'b1, 2'd3, 8'hA5, 4'hF, acc);
    idle(4'hF, 2);

    // Fill channel 1 and backpressure the third beat
    step(1'b1, 2'd1, 8'h11, 4'h0, acc);
    step(1'b1, 2'd1, 8'h22, 4'h0, acc);
    step(1'b1, 2'd1, 8'h33, 4'h0, acc);
    step(1'b1, 2'd1, 8'h33, 4'h2, acc);
    step(1'b1, 2'd1, 8'h33, 4'h2, acc);
    idle(4'h2, 2);

    // Head-of-line: dest=0 stalls on full channel 0, dest=2 waits behind it
    step(1'b1, 2'd0, 8'hA0, 4'h0, acc);
    step(1'b1, 2'd0, 8'hA1, 4'h0, acc);
    step(1'b1, 2'd0, 8'hA2, 4'h0, acc);
    step(1'b1, 2'd0, 8'hA2, 4'h0, acc);
    step(1'b1, 2'd0, 8'hA2, 4'h1, acc);
    step(1'b1, 2'd0, 8'hA2, 4'h0, acc);
    step(1'b1, 2'd2, 8'hB0, 4'h0, acc);
    idle(4'hF, 4);

    // Concurrent push and pop on channel 2
    step(1'b1, 2'd2, 8'hC1, 4'h0, acc);
    step(1'b1, 2'd2, 8'hC2, 4'h4, acc);
    idle(4'h0, 1);
    idle(4'hF, 2);

    // Round-robin random stream with random consumer readiness
    for (int b = 0; b < 40; b++) begin
      d   = 2'(b % NUM_CH);
      dat = 8'($urandom);
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++)
        step(1'b1, d, dat, 4'($urandom_range(0, 15)), acc);
      if (!acc) chk("rand_timeout", 32'd0, 32'd1);
    end
    idle(4'hF, 4);

    // Mid-stream reset with channel 2 holding two beats
    step(1'b1, 2'd2, 8'hD1, 4'h0, acc);
    step(1'b1, 2'd2, 8'hD2, 4'h0, acc);
    idle(4'h0, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset_model();
    #3 rst_n = 1'b1;
    idle(4'hF, 3);

`ifdef DEMUX_ROUTER_CNT_EN
    for (int b = 0; b < 17; b++) send(2'd0, 8'(8'h40 + b), 4'h1);
    idle(4'h1, 3);
    chk("cnt_wrap0", 32'(bus.out_cnt[0 +: CW]), 32'd1);
    chk("cnt_other", 32'(bus.out_cnt[NUM_CH*CW-1:CW]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Registered, flow-controlled routing stage that sits downstream of the 1-to-4 demux select logic.
- Accepts a stream of (dest, data) beats on a valid/ready input and steers each beat to one of 4 output channels.
- Each output channel has its own small FIFO so that a stalled consumer blocks only beats addressed to it, and only while its FIFO is full.
- Replaces the bare combinational demux wherever the consumers apply backpressure.

Parameters:
- DATA_W, 8, width of the data field of each beat.
- DEPTH, 2, entries per channel FIFO; must be a power of 2 and at least 2.
- CNT_W, 16, width of the per-channel beat counters (optional feature only).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid is also high.
- in_dest  input  2  destination channel, 0..3.
- in_data  input  DATA_W  beat payload.
- out_valid  output  4  bit k is high when channel k has a beat available.
- out_ready  input  4  bit k is high when the channel k consumer takes the beat.
- out_data  output  4*DATA_W  channel k data on bits [k*DATA_W +: DATA_W].
- out_cnt  output  4*CNT_W  channel k accepted-beat count; present only with DEMUX_ROUTER_CNT_EN.

Behaviour:
- Reset is asynchronous and active-low; it is the only reset. While rst_n=0:
  - All FIFO pointers and occupancy counts clear.
  - out_valid=4'b0000 and in_ready=0.
  - out_data is don't-care but must not be X-propagated into control.
  - out_cnt clears to 0.
- After release, in_ready=1 on the first clock edge.
- Reset mid-operation discards all buffered beats; no beat reappears after reset.
- Input handshake: a beat transfers on a clk edge where in_valid=1 and in_ready=1.
- in_ready = !full[in_dest]. This is combinational from in_dest and registered occupancy only, never from out_ready.
- A full channel does not accept a push even if the same channel pops in that cycle.
- Head-of-line blocking is intended: a beat for a full channel stalls the input, and later beats for other channels wait behind it.
- The source must hold in_dest and in_data stable while in_valid=1 and in_ready=0.
- Latency: a beat accepted at edge N is visible on out_valid[k] and out_data[k] after edge N. Minimum one cycle; there is no combinational bypass.
- Output handshake per channel: pop on an edge where out_valid[k]=1 and out_ready[k]=1.
  - out_data[k] always shows the FIFO head.
  - out_valid[k]=(count[k]!=0).
- All four channels may pop in the same cycle, independently of each other.
- Push and pop on the same non-full, non-empty channel in one cycle: count is unchanged and ordering is preserved.
- Push to an empty channel while out_ready[k]=1: the beat is not popped that cycle because it is not yet visible.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy is held in a separate count of log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Per-channel FIFO order is strict FIFO. There is no ordering guarantee across channels.
- in_dest values are all legal (2 bits), so there is no error path.

Optional Feature:
- Macro: DEMUX_ROUTER_CNT_EN.
- Defined:
  - Each channel has a CNT_W-bit counter that increments on every accepted input beat routed to it.
  - The counter wraps from all-ones to 0 and resets to 0.
  - The count is exported on out_cnt.
- Undefined: the counters and the out_cnt port do not exist. All other behaviour is identical.

Decomposition:
- Package demux_router_pkg holds:
  - NUM_CH=4 and DEST_W=2;
  - typedef dest_t (logic [DEST_W-1:0]);
  - the default DATA_W and DEPTH constants.
- Sub-module demux_chan_fifo is a single-clock FIFO with count-based full and empty.
  - It has ports clk, rst_n, push, pop, wdata, rdata, full, empty.
  - It is instantiated NUM_CH times in a generate loop.
- The top level holds the push decode (demux of the accepted handshake by in_dest), the in_ready mux and the optional counters.

Test Plan:
- Reset then idle: assert rst_n=0 mid-stream with channel 2 holding 2 beats -> out_valid=0000 immediately (asynchronously); after release out_valid=0000, in_ready=1, out_cnt=0.
- Single route: in_dest=3, in_data=8'hA5 for one cycle, out_ready=1111 -> next cycle out_valid=1000 and out_data[3]=A5; popped that edge, then out_valid=0000.
- Fill and backpressure: 3 beats to channel 1 (11,22,33) with out_ready=0000 -> first two accepted; in_ready=0 on the third. Raise out_ready[1] -> 11 and then 22 emerge in order, and 33 is accepted the cycle after the first pop.
- Head-of-line: channel 0 full; input beat dest=0 followed by dest=2 -> the dest=2 beat is not accepted until channel 0 pops; channel 2 sees nothing meanwhile.
- Concurrent pop and push: channel 2 holds 1 beat; push dest=2 while out_ready[2]=1 -> count stays 1, the old beat exits and the new beat is the head next cycle. Then stream 10 beats to each channel round-robin with random out_ready -> per-channel order intact, no loss.
- With DEMUX_ROUTER_CNT_EN and CNT_W=4: send 17 beats to channel 0 -> out_cnt[0]=1 (wrapped); other channels 0.
